rf_wb_arbiter: RTL
==================

Name: rf_wb_arbiter

Overview:
- Shares the single register-file write port (WNUM/WDATA, written on posedge CLK, WNUM=0 means no write) between two requesters:
  - A: in-order pipeline writeback; priority, no backpressure.
  - B: long-latency unit (load/mul-div); valid/ready handshake, buffered in a small FIFO.
- Keeps a pending-write scoreboard of B destinations for the hazard unit.
- Guarantees B forward progress with a starvation timer that freezes A for one cycle.

Parameters:
- DEPTH, 4, B FIFO entries; power of two, >=2.
- MAX_WAIT, 8, cycles a non-empty FIFO head may wait before A is stalled; >=1.

Ports:
- CLK  in  1  clock
- RST_N  in  1  asynchronous active-low reset
- A_VALID  in  1  writeback request from pipeline
- A_WNUM  in  5  destination register
- A_WDATA  in  32  write data
- B_VALID  in  1  B result valid
- B_READY  out  1  FIFO can accept (= !full)
- B_WNUM  in  5  B destination register
- B_WDATA  in  32  B write data
- B_ISSUE  in  1  B operation issued (scoreboard set)
- B_ISSUE_RD  in  5  destination of issued B operation
- QRS1  in  5  hazard query
- QRS2  in  5  hazard query
- QRD  in  5  hazard query
- BUSY_RS1  out  1  pending[QRS1] && QRS1!=0, combinational
- BUSY_RS2  out  1  as above for QRS2
- BUSY_RD  out  1  as above for QRD
- STALL_A  out  1  registered; pipeline must freeze WB and re-present its request next cycle
- RF_WNUM  out  5  to register file WNUM, registered
- RF_WDATA  out  32  to register file WDATA, registered
- STALL_CNT  out  16  stall statistics (see optional feature)

Behaviour:
- Reset (RST_N=0, async): RF_WNUM=0, RF_WDATA=0, STALL_A=0, FIFO empty, B_READY=1, pending=0, wait counter=0, STALL_CNT=0. Reset mid-operation discards all FIFO contents and pending bits.
- Push:
  - A B entry is pushed when B_VALID && B_READY.
  - Entries with B_WNUM=0 are accepted but discarded.
  - B_READY depends only on current occupancy. When full, no push occurs even if a pop happens the same cycle.
- Grant per cycle, priority order:
  1. A, if A_VALID && A_WNUM!=0 && !STALL_A.
  2. Otherwise the FIFO head, if the FIFO is not empty (pop).
  3. Otherwise none.
- A_VALID with A_WNUM=0 is a no-op and leaves the port free for B. An A request present while STALL_A=1 is ignored.
- Output:
  - On the posedge, RF_WNUM/RF_WDATA load the granted entry, or 0/hold data if there is no grant.
  - Latency from request to RF write port is 1 cycle; the RF commits on the following edge.
  - Internal flag from_b records that the current RF_WNUM came from B.
- Starvation timer:
  - wait_cnt increments on each cycle where the FIFO is non-empty and no pop occurs; it clears on pop or when the FIFO is empty.
  - When wait_cnt==MAX_WAIT, STALL_A is registered high for exactly one cycle and wait_cnt clears.
  - In the STALL_A cycle the head is popped unconditionally; the FIFO cannot be empty at that point.
- Scoreboard (pending[31:1]):
  - Set: on posedge when B_ISSUE && B_ISSUE_RD!=0.
  - Clear: bit RF_WNUM is cleared on the posedge at which the RF commits a B write (from_b=1 && RF_WNUM!=0). BUSY therefore falls in the cycle after RF_WNUM shows the register, so the negedge RF read sees the new value.
  - Simultaneous set and clear of the same register: set wins.
- Issuer contract:
  - Must not B_ISSUE to a register with BUSY_RD=1.
  - Must not send A writes to a pending rd. This preserves WAW ordering.
- FIFO order is strict FIFO. Pointers wrap modulo DEPTH, and full/empty are distinguished by an extra pointer bit.

Optional Feature:
- Macro: RF_WB_ARB_STATS_EN.
- Defined: STALL_CNT increments on each cycle STALL_A=1, saturates at 0xFFFF, and clears only on reset.
- Undefined: STALL_CNT is tied to 0 and no counter logic is generated.

Test Plan:
- A only: A_VALID=1, A_WNUM=5, A_WDATA=0x0000_1234 → next cycle RF_WNUM=5, RF_WDATA=0x1234; one cycle later the register file reads x5=0x1234.
- B while A idle: push B_WNUM=9, B_WDATA=0xDEAD_BEEF with A_VALID=0 → RF_WNUM=9 two cycles after push (1 cycle FIFO + 1 output).
- Priority/starvation with MAX_WAIT=8: A_VALID=1 every cycle (A_WNUM=3), one B entry (B_WNUM=4) pushed →
  - STALL_A=1 for exactly one cycle after 8 waiting cycles.
  - Next cycle RF_WNUM=4.
  - A's request re-presented in the following cycle is written.
  - STALL_CNT=1 when RF_WB_ARB_STATS_EN is defined.
- FIFO full: A busy, push 4 B entries → B_READY=0. A 5th B_VALID is not accepted. After A idles, the entries drain in push order and B_READY returns to 1 after the first pop.
- Scoreboard: B_ISSUE with rd=7 → BUSY_RD=1 for QRD=7, BUSY_RS1=0 for QRS1=0. After the B write to 7 appears on RF_WNUM, BUSY falls exactly one cycle later. Same-edge reissue to rd=7 keeps BUSY=1.
- Async reset mid-drain: RST_N low with 3 FIFO entries and pending bits set → immediately RF_WNUM=0, STALL_A=0, B_READY=1, all BUSY=0; no writes after release.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback (A) over a FIFO-buffered long-latency unit (B),
// with a pending-write scoreboard and starvation timer. Define RF_WB_ARB_STATS_EN to enable STALL_CNT.
module rf_wb_arbiter #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        A_VALID,
  input  logic [4:0]  A_WNUM,
  input  logic [31:0] A_WDATA,
  input  logic        B_VALID,
  output logic        B_READY,
  input  logic [4:0]  B_WNUM,
  input  logic [31:0] B_WDATA,
  input  logic        B_ISSUE,
  input  logic [4:0]  B_ISSUE_RD,
  input  logic [4:0]  QRS1,
  input  logic [4:0]  QRS2,
  input  logic [4:0]  QRD,
  output logic        BUSY_RS1,
  output logic        BUSY_RS2,
  output logic        BUSY_RD,
  output logic        STALL_A,
  output logic [4:0]  RF_WNUM,
  output logic [31:0] RF_WDATA,
  output logic [15:0] STALL_CNT
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned WW = $clog2(MAX_WAIT + 1);

  logic [AW:0]   wr_ptr, rd_ptr;
  logic [4:0]    fifo_wnum  [DEPTH];
  logic [31:0]   fifo_wdata [DEPTH];
  logic [WW-1:0] wait_cnt;
  logic [31:1]   pending, pending_nxt;
  logic [31:0]   pending_vec;
  logic          from_b;
  logic          empty, full, push, pop, grant_a;

  // Extra pointer bit tells full from empty when the index bits match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign B_READY = !full;

  // Zero-destination B results complete the handshake but never occupy an entry.
  assign push    = B_VALID && !full && (B_WNUM != 5'd0);
  assign grant_a = A_VALID && (A_WNUM != 5'd0) && !STALL_A;
  assign pop     = !grant_a && !empty;

  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_wnum[wr_ptr[AW-1:0]]  <= B_WNUM;
      fifo_wdata[wr_ptr[AW-1:0]] <= B_WDATA;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wait_cnt <= '0;
      STALL_A  <= 1'b0;
    end else begin
      STALL_A <= 1'b0;
      if (empty || pop) begin
        wait_cnt <= '0;
      end else if (wait_cnt == WW'(MAX_WAIT)) begin
        wait_cnt <= '0;
        STALL_A  <= 1'b1;
      end else begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      RF_WNUM  <= '0;
      RF_WDATA <= '0;
      from_b   <= 1'b0;
    end else if (grant_a) begin
      RF_WNUM  <= A_WNUM;
      RF_WDATA <= A_WDATA;
      from_b   <= 1'b0;
    end else if (pop) begin
      RF_WNUM  <= fifo_wnum[rd_ptr[AW-1:0]];
      RF_WDATA <= fifo_wdata[rd_ptr[AW-1:0]];
      from_b   <= 1'b1;
    end else begin
      RF_WNUM  <= '0;
      from_b   <= 1'b0;
    end
  end

  // Set is applied after clear so a same-edge reissue keeps the bit.
  always_comb begin
    pending_nxt = pending;
    for (int unsigned i = 1; i < 32; i++) begin
      if (from_b && (RF_WNUM == 5'(i)))    pending_nxt[i] = 1'b0;
      if (B_ISSUE && (B_ISSUE_RD == 5'(i))) pending_nxt[i] = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) pending <= '0;
    else        pending <= pending_nxt;
  end

  assign pending_vec = {pending, 1'b0};
  assign BUSY_RS1    = (QRS1 != 5'd0) && pending_vec[QRS1];
  assign BUSY_RS2    = (QRS2 != 5'd0) && pending_vec[QRS2];
  assign BUSY_RD     = (QRD  != 5'd0) && pending_vec[QRD];

`ifdef RF_WB_ARB_STATS_EN
  logic [15:0] stall_cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                          stall_cnt <= '0;
    else if (STALL_A && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
  end

  assign STALL_CNT = stall_cnt;
`else
  assign STALL_CNT = '0;
`endif

endmodule
